thor2023_dcline_state: RTL and testbench

Per-line, per-way valid and dirty state array for the Thor2023 write-back data cache. Sits beside the data cache tag RAM. Records fills and write hits, and performs invalidate or flush operations for a single line or the whole cache through a sequential sweep state machine. In flush mode, every dirty line is handed to the cache controller for write-back through a req/ack handshake before it is cleared.

---
 rtl/thor2023_dcline_state_pkg.sv | 13 +
 rtl/thor2023_dcline_state_ffo.sv | 19 +
 rtl/thor2023_dcline_state.sv | 156 +++++++++++++++
 tb/tb_thor2023_dcline_state.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/thor2023_dcline_state_pkg.sv
// Shared Thor2023 types used by the data cache line-state array.
package Thor2023Pkg;

  typedef logic [31:0] Address;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    WB_WAIT = 2'd2,
    DONE    = 2'd3
  } dcls_state_t;

endpackage

// File: rtl/thor2023_dcline_state_ffo.sv
// Lowest-set-bit encoder over the way vector; picks the next way to write back.
module thor2023_ffo_way #(
  parameter  int WAYS = 4,
  localparam int WB   = $clog2(WAYS)
)(
  input  logic [WAYS-1:0] i_vec,
  output logic [WB-1:0]   o_way,
  output logic            o_found
);

  always_comb begin
    o_way   = '0;
    o_found = |i_vec;
    // Walk downward so the lowest set bit is the last (winning) assignment.
    for (int i = WAYS - 1; i >= 0; i--)
      if (i_vec[i]) o_way = WB'(i);
  end

endmodule

// File: rtl/thor2023_dcline_state.sv
// Per-line, per-way valid/dirty array for the Thor2023 write-back data cache,
// with a sequential invalidate/flush sweep that hands dirty lines to the controller.
module thor2023_dcline_state
  import Thor2023Pkg::*;
#(
  parameter  int LINES = 256,
  parameter  int WAYS  = 4,
  parameter  int LOBIT = 6,
  localparam int WB    = $clog2(WAYS),
  localparam int IW    = $clog2(LINES),
  localparam int HIBIT = IW - 1 + LOBIT
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill,
  input  Address                       fill_adr,
  input  logic [WB-1:0]                fill_way,
  input  logic                         wr_hit,
  input  Address                       wr_adr,
  input  logic [WB-1:0]                wr_way,
  input  logic                         inv_req,
  output logic                         inv_ack,
  input  logic                         inv_all,
  input  logic                         inv_flush,
  input  Address                       inv_adr,
  input  logic [WAYS-1:0]              inv_wmask,
  output logic                         busy,
  output logic                         done,
  output logic                         wb_req,
  output logic [IW-1:0]                wb_line,
  output logic [WB-1:0]                wb_way,
  input  logic                         wb_ack,
  output logic [WAYS-1:0][LINES-1:0]   valid,
  output logic [WAYS-1:0][LINES-1:0]   dirty
);

  dcls_state_t                r_state, w_next;
  logic [IW-1:0]              r_idx, r_end;
  logic                       r_flush;
  logic [WAYS-1:0]            r_mask;
  logic [IW-1:0]              r_wb_line;
  logic [WB-1:0]              r_wb_way;
  logic [WAYS-1:0][LINES-1:0] r_valid, r_dirty;

  logic [WAYS-1:0] w_d;
  logic [WB-1:0]   w_ffo_way;
  logic            w_found;
  logic            w_scan_wb;
  logic            w_last;
  logic [IW-1:0]   w_fill_idx, w_wr_idx, w_inv_idx;
  logic            w_unused;

  assign w_fill_idx = fill_adr[HIBIT:LOBIT];
  assign w_wr_idx   = wr_adr[HIBIT:LOBIT];
  assign w_inv_idx  = inv_adr[HIBIT:LOBIT];
  assign w_unused   = ^{fill_adr, wr_adr, inv_adr};

  // Dirty-and-valid ways at the sweep index that the operation is allowed to touch.
  always_comb begin
    w_d = '0;
    for (int w = 0; w < WAYS; w++)
      w_d[w] = r_valid[w][r_idx] & r_dirty[w][r_idx] & r_mask[w];
  end

  thor2023_ffo_way #(.WAYS(WAYS)) u_ffo (
    .i_vec   (w_d),
    .o_way   (w_ffo_way),
    .o_found (w_found)
  );

  assign w_scan_wb = r_flush & w_found;
  assign w_last    = (r_idx == r_end);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (inv_req) w_next = SCAN;
      SCAN:    if (w_scan_wb)   w_next = WB_WAIT;
               else if (w_last) w_next = DONE;
      WB_WAIT: if (wb_ack) w_next = SCAN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    inv_ack = inv_req & (r_state == IDLE);
    busy    = (r_state != IDLE);
    done    = (r_state == DONE);
    wb_req  = (r_state == WB_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_end     <= '0;
      r_flush   <= 1'b0;
      r_mask    <= '0;
      r_wb_line <= '0;
      r_wb_way  <= '0;
    end else begin
      case (r_state)
        IDLE: if (inv_req) begin
          r_idx   <= inv_all ? '0 : w_inv_idx;
          r_end   <= inv_all ? IW'(LINES - 1) : w_inv_idx;
          r_flush <= inv_flush;
          r_mask  <= inv_wmask;
        end
        // After a write-back the index holds, so the same line is re-evaluated.
        SCAN: if (w_scan_wb) begin
          r_wb_line <= r_idx;
          r_wb_way  <= w_ffo_way;
        end else if (!w_last) begin
          r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sweep clears are written first so a same-cycle fill or store wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (r_state == SCAN && !w_scan_wb)
        for (int w = 0; w < WAYS; w++)
          if (r_mask[w]) begin
            r_valid[w][r_idx] <= 1'b0;
            r_dirty[w][r_idx] <= 1'b0;
          end
      if (r_state == WB_WAIT && wb_ack) begin
        r_valid[r_wb_way][r_wb_line] <= 1'b0;
        r_dirty[r_wb_way][r_wb_line] <= 1'b0;
      end
      if (fill) begin
        r_valid[fill_way][w_fill_idx] <= 1'b1;
        r_dirty[fill_way][w_fill_idx] <= 1'b0;
      end
      if (wr_hit)
        r_dirty[wr_way][w_wr_idx] <= 1'b1;
    end
  end

  assign wb_line = r_wb_line;
  assign wb_way  = r_wb_way;
  assign valid   = r_valid;
  assign dirty   = r_dirty;

endmodule

// File: tb/tb_thor2023_dcline_state.sv
// Randomized bench for thor2023_dcline_state against a line/way array model.
module tb_thor2023_dcline_state;
  localparam int LINES = 256;
  localparam int WAYS  = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        fill = 1'b0, wr_hit = 1'b0, inv_req = 1'b0, inv_all = 1'b0, inv_flush = 1'b0;
  logic        wb_ack = 1'b0;
  logic [31:0] fill_adr = '0, wr_adr = '0, inv_adr = '0;
  logic [1:0]  fill_way = '0, wr_way = '0;
  logic [3:0]  inv_wmask = '0;
  logic        inv_ack, busy, done, wb_req;
  logic [7:0]  wb_line;
  logic [1:0]  wb_way;
  logic [WAYS-1:0][LINES-1:0] valid, dirty;

  int total = 0, bad = 0;
  bit mv[WAYS][LINES];
  bit md[WAYS][LINES];

  thor2023_dcline_state dut (
    .clk(clk), .rst(rst),
    .fill(fill), .fill_adr(fill_adr), .fill_way(fill_way),
    .wr_hit(wr_hit), .wr_adr(wr_adr), .wr_way(wr_way),
    .inv_req(inv_req), .inv_ack(inv_ack), .inv_all(inv_all), .inv_flush(inv_flush),
    .inv_adr(inv_adr), .inv_wmask(inv_wmask),
    .busy(busy), .done(done),
    .wb_req(wb_req), .wb_line(wb_line), .wb_way(wb_way), .wb_ack(wb_ack),
    .valid(valid), .dirty(dirty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkadr(input int line);
    logic [31:0] a;
    a = $urandom;
    a[13:6] = 8'(line);
    return a;
  endfunction

  task automatic chk_arr(input string tag);
    for (int w = 0; w < WAYS; w++) begin
      logic [255:0] ev, ed;
      for (int l = 0; l < LINES; l++) begin
        ev[l] = mv[w][l];
        ed[l] = md[w][l];
      end
      chk($sformatf("%s_valid%0d", tag, w), valid[w], ev);
      chk($sformatf("%s_dirty%0d", tag, w), dirty[w], ed);
    end
  endtask

  task automatic clear_model();
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++) begin
        mv[w][l] = 0;
        md[w][l] = 0;
      end
  endtask

  task automatic step(input bit f, input int fl, input int fw, input bit s, input int sl, input int sw);
    fill = f;   fill_adr = mkadr(fl); fill_way = 2'(fw);
    wr_hit = s; wr_adr = mkadr(sl);   wr_way = 2'(sw);
    tick();
    fill = 0; wr_hit = 0;
    if (f) begin mv[fw][fl] = 1; md[fw][fl] = 0; end
    if (s) md[sw][sl] = 1;
  endtask

  task automatic rand_phase(input int n);
    for (int k = 0; k < n; k++) begin
      int fl, fw, sl, sw;
      fl = $urandom_range(LINES-1); fw = $urandom_range(WAYS-1);
      if ($urandom_range(3) == 0) begin sl = fl; sw = fw; end
      else begin sl = $urandom_range(LINES-1); sw = $urandom_range(WAYS-1); end
      wb_ack = 1'($urandom);
      step(1'($urandom), fl, fw, 1'($urandom), sl, sw);
    end
    wb_ack = 0;
  endtask

  // Expected write-backs are listed from a snapshot: line order, then ascending way.
  task automatic run_op(input bit all, input bit fl, input int line, input logic [3:0] m,
                        input int dmin, input int dmax);
    int lo, hi, exp_t, cnt, d, t;
    int ql[$], qw[$], qd[$];
    bit seen_done, extra;
    lo = all ? 0 : line;
    hi = all ? LINES-1 : line;
    exp_t = hi - lo + 2;
    if (fl)
      for (int i = lo; i <= hi; i++)
        for (int w = 0; w < WAYS; w++)
          if (m[w] && mv[w][i] && md[w][i]) begin
            d = $urandom_range(dmax, dmin);
            ql.push_back(i); qw.push_back(w); qd.push_back(d);
            exp_t += d + 2;
          end
    inv_req = 1; inv_all = all; inv_flush = fl; inv_adr = mkadr(line); inv_wmask = m;
    #1 chk("inv_ack", inv_ack, 1);
    tick();
    inv_req = 0; inv_all = 1'($urandom); inv_flush = 1'($urandom);
    inv_wmask = 4'($urandom); inv_adr = $urandom;
    cnt = 0; seen_done = 0; extra = 0;
    for (t = 1; t <= exp_t + 20 && !seen_done; t++) begin
      wb_ack = 0;
      if (t == 1) begin
        chk("busy", busy, 1);
        inv_req = 1;
        #1 chk("ack_when_busy", inv_ack, 0);
        inv_req = 0;
      end
      if (wb_req) begin
        if (ql.size() == 0) begin
          if (!extra) chk("wb_extra", wb_req, 0);
          extra = 1;
        end else begin
          chk("wb_line", wb_line, ql[0]);
          chk("wb_way", wb_way, qw[0]);
          cnt++;
          if (cnt == qd[0] + 1) begin
            wb_ack = 1;
            void'(ql.pop_front()); void'(qw.pop_front()); void'(qd.pop_front());
            cnt = 0;
          end
        end
      end
      if (done) begin
        chk("done_time", t, exp_t);
        seen_done = 1;
      end else begin
        tick();
      end
    end
    wb_ack = 0;
    if (!seen_done) chk("done_timeout", 0, 1);
    chk("wb_left", ql.size(), 0);
    tick();
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    for (int i = lo; i <= hi; i++)
      for (int w = 0; w < WAYS; w++)
        if (m[w]) begin mv[w][i] = 0; md[w][i] = 0; end
    chk_arr("op");
  endtask

  initial begin
    clear_model();
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_wb_line", wb_line, 0);
    chk("rst_wb_way", wb_way, 0);
    chk_arr("rst");
    rst = 0;
    tick();

    // Fill then store to line 7 way 2.
    fill = 1; fill_adr = 32'h1C0; fill_way = 2; tick(); fill = 0;
    mv[2][7] = 1; md[2][7] = 0;
    chk("fill_v", valid[2][7], 1);
    chk("fill_d", dirty[2][7], 0);
    wr_hit = 1; wr_adr = 32'h1C0; wr_way = 2; tick(); wr_hit = 0;
    md[2][7] = 1;
    chk("store_d", dirty[2][7], 1);
    chk("store_v", valid[2][7], 1);

    rand_phase(400);
    chk_arr("rand");

    run_op(1, 0, 0, 4'hF, 0, 0);

    // Flush one line: ways 1 and 3 dirty, way 0 clean-valid.
    step(1, 7, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0);
    step(1, 7, 3, 1, 7, 1);
    step(0, 0, 0, 1, 7, 3);
    run_op(0, 1, 7, 4'hF, 3, 3);

    rand_phase(300);
    run_op(1, 1, 0, 4'b0001, 0, 2);

    rand_phase(100);
    run_op(1, 1, 0, 4'b0000, 0, 0);

    // Fill lands in the same cycle the sweep clears line 5.
    for (int w = 0; w < WAYS; w++) step(1, 5, w, 1, 5, w);
    inv_req = 1; inv_all = 0; inv_flush = 0; inv_adr = mkadr(5); inv_wmask = 4'hF;
    #1 chk("sim_ack", inv_ack, 1);
    tick();
    inv_req = 0;
    fill = 1; fill_adr = mkadr(5); fill_way = 0;
    tick();
    fill = 0;
    chk("sim_done", done, 1);
    tick();
    for (int w = 0; w < WAYS; w++) begin mv[w][5] = 0; md[w][5] = 0; end
    mv[0][5] = 1;
    chk_arr("sim");

    for (int k = 0; k < 4; k++) begin
      rand_phase(100);
      run_op(1'($urandom), 1'($urandom), $urandom_range(LINES-1), 4'($urandom), 0, 3);
    end

    // Reset while waiting for a write-back ack.
    step(1, 9, 2, 0, 0, 0);
    step(0, 0, 0, 1, 9, 2);
    inv_req = 1; inv_all = 0; inv_flush = 1; inv_adr = mkadr(9); inv_wmask = 4'hF;
    tick();
    inv_req = 0;
    for (int k = 0; k < 10 && !wb_req; k++) tick();
    chk("rstwb_req_seen", wb_req, 1);
    rst = 1;
    tick();
    chk("rstwb_req", wb_req, 0);
    chk("rstwb_busy", busy, 0);
    clear_model();
    chk_arr("rstwb");
    rst = 0;
    wb_ack = 1;
    tick();
    wb_ack = 0;
    chk("late_ack_busy", busy, 0);
    chk("late_ack_req", wb_req, 0);
    chk("late_ack_done", done, 0);
    tick();
    chk_arr("late_ack");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
